pwm_deadtime_gen: RTL and testbench

- Per-channel output stage directly downstream of each EF_TMR32_WB PWM timer, placed between timer pwm0 and the user GPIO pads.
- Converts one PWM reference into complementary high-side/low-side drives with programmable break-before-make dead time.
- Adds a filtered, sticky pad fault input that forces both drives low and raises an interrupt pulse.
- The user wrapper instantiates one per timer; dead-time and control inputs come from wrapper-level Wishbone registers.

---
 rtl/pwm_dt_pkg.sv | 30 +++
 rtl/pwm_fault_filter.sv | 35 +++
 rtl/pwm_deadtime_gen.sv | 126 ++++++++++++
 tb/tb_pwm_deadtime_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_dt_pkg.sv
// Shared types and defaults for the complementary PWM dead-time output stage.
package pwm_dt_pkg;

  localparam int DT_W_DEF     = 8;
  localparam int FLT_FILT_DEF = 4;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DT_HI = 3'd1,
    ST_HI    = 3'd2,
    ST_DT_LO = 3'd3,
    ST_LO    = 3'd4,
    ST_FAULT = 3'd5
  } pwm_st_e;

  // Drive decode per state: {hs, ls, dt_active}.
  function automatic logic [2:0] drv_decode(input pwm_st_e st);
    logic [2:0] d;
    d = 3'b000;
    case (st)
      ST_HI:    d = 3'b100;
      ST_LO:    d = 3'b010;
      ST_DT_HI: d = 3'b001;
      ST_DT_LO: d = 3'b001;
      default:  d = 3'b000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pwm_fault_filter.sv
// Pad fault conditioning: 2-flop synchronizer followed by a saturating
// consecutive-high counter; a fault is declared once the count saturates.
module pwm_fault_filter #(
  parameter int FLT_FILT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic fault_i,
  output logic flt_det_o,
  output logic flt_sync_o
);

  localparam int CW = $clog2(FLT_FILT + 1);
  localparam logic [CW-1:0] FLT_MAX = CW'(FLT_FILT);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= 2'b00;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], fault_i};
      if (!r_sync[1])
        r_cnt <= '0;
      else if (r_cnt != FLT_MAX)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign flt_sync_o = r_sync[1];
  assign flt_det_o  = (r_cnt == FLT_MAX);

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low-side driver with break-before-make dead time and a
// filtered sticky fault that forces both drives off.
module pwm_deadtime_gen
  import pwm_dt_pkg::*;
#(
  parameter int DT_W     = DT_W_DEF,
  parameter int FLT_FILT = FLT_FILT_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            pwm_i,
  input  logic [DT_W-1:0] dt_rise_i,
  input  logic [DT_W-1:0] dt_fall_i,
  input  logic            fault_i,
  input  logic            fault_clr_i,
  output logic            hs_o,
  output logic            ls_o,
  output logic            dt_active_o,
  output logic            fault_o,
  output logic            fault_irq_o
);

  pwm_st_e         r_state, w_next;
  logic [DT_W-1:0] r_cnt, w_cnt_nxt;
  logic            w_flt_det, w_flt_sync;
  logic [2:0]      w_drv;
  logic            r_hs, r_ls, r_dta, r_flt, r_irq;

  pwm_fault_filter #(.FLT_FILT(FLT_FILT)) u_filt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .fault_i    (fault_i),
    .flt_det_o  (w_flt_det),
    .flt_sync_o (w_flt_sync)
  );

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    if (r_state == ST_FAULT) begin
      // A clear coinciding with a still-declared fault is ignored.
      if (fault_clr_i && !w_flt_sync && !w_flt_det)
        w_next = ST_OFF;
    end else if (w_flt_det) begin
      w_next = ST_FAULT;
    end else if (!en_i) begin
      w_next = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (pwm_i) begin
            w_next    = ST_DT_HI;
            w_cnt_nxt = dt_rise_i;
          end else begin
            w_next    = ST_DT_LO;
            w_cnt_nxt = dt_fall_i;
          end
        end
        ST_DT_HI: begin
          if (!pwm_i) begin
            w_next    = ST_DT_LO;
            w_cnt_nxt = dt_fall_i;
          end else if (r_cnt == '0) begin
            w_next = ST_HI;
          end else begin
            w_cnt_nxt = r_cnt - DT_W'(1);
          end
        end
        ST_HI: begin
          if (!pwm_i) begin
            w_next    = ST_DT_LO;
            w_cnt_nxt = dt_fall_i;
          end
        end
        ST_DT_LO: begin
          if (pwm_i) begin
            w_next    = ST_DT_HI;
            w_cnt_nxt = dt_rise_i;
          end else if (r_cnt == '0) begin
            w_next = ST_LO;
          end else begin
            w_cnt_nxt = r_cnt - DT_W'(1);
          end
        end
        ST_LO: begin
          if (pwm_i) begin
            w_next    = ST_DT_HI;
            w_cnt_nxt = dt_rise_i;
          end
        end
        default: w_next = ST_OFF;
      endcase
    end
  end

  assign w_drv = drv_decode(w_next);

  // Outputs are decoded from the next state so they move with the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_hs    <= 1'b0;
      r_ls    <= 1'b0;
      r_dta   <= 1'b0;
      r_flt   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_hs    <= w_drv[2];
      r_ls    <= w_drv[1];
      r_dta   <= w_drv[0];
      r_flt   <= (w_next == ST_FAULT);
      r_irq   <= (w_next == ST_FAULT) && (r_state != ST_FAULT);
    end
  end

  assign hs_o        = r_hs;
  assign ls_o        = r_ls;
  assign dt_active_o = r_dta;
  assign fault_o     = r_flt;
  assign fault_irq_o = r_irq;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench: the driver queues the expected output vector for each
// clock, an independent monitor pops and compares it after the edge.
module tb_pwm_deadtime_gen;

  localparam logic [4:0] E_OFF  = 5'b00000; // {hs, ls, dt_active, fault, irq}
  localparam logic [4:0] E_DT   = 5'b00100;
  localparam logic [4:0] E_HI   = 5'b10000;
  localparam logic [4:0] E_LO   = 5'b01000;
  localparam logic [4:0] E_FIRQ = 5'b00011;
  localparam logic [4:0] E_FLT  = 5'b00010;

  typedef struct {
    logic [4:0] v;
    string      nm;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i, pwm_i, fault_i, fault_clr_i;
  logic [7:0] dt_rise_i, dt_fall_i;
  logic       hs_o, ls_o, dt_active_o, fault_o, fault_irq_o;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  pwm_deadtime_gen #(.DT_W(8), .FLT_FILT(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .pwm_i       (pwm_i),
    .dt_rise_i   (dt_rise_i),
    .dt_fall_i   (dt_fall_i),
    .fault_i     (fault_i),
    .fault_clr_i (fault_clr_i),
    .hs_o        (hs_o),
    .ls_o        (ls_o),
    .dt_active_o (dt_active_o),
    .fault_o     (fault_o),
    .fault_irq_o (fault_irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Expect v after the next rising edge, then advance to the next falling edge.
  task automatic cyc(input logic [4:0] v, input string nm);
    exp_t e;
    e.v  = v;
    e.nm = nm;
    sb_q.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic async_rst();
    exp_t e;
    #2;
    e.v  = E_OFF;
    e.nm = "async_rst";
    sb_q.push_back(e);
    rst_ni = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [4:0] act;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      #1;
      if (sb_q.size() != 0) begin
        e   = sb_q.pop_front();
        act = {hs_o, ls_o, dt_active_o, fault_o, fault_irq_o};
        n_chk++;
        if (act !== e.v) begin
          n_err++;
          $display("FAIL %s: got %b expected %b (hs,ls,dt,flt,irq) t=%0t",
                   e.nm, act, e.v, $time);
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      n_chk++;
      if (hs_o && ls_o) begin
        n_err++;
        $display("FAIL shoot_through: hs=%b ls=%b required not both 1 t=%0t",
                 hs_o, ls_o, $time);
      end
    end
  end

  initial begin : watchdog
    repeat (3000) @(posedge clk_i);
    $display("FAIL watchdog: cycle budget expired, required test completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst_ni = 1'b0; en_i = 1'b0; pwm_i = 1'b0; fault_i = 1'b0; fault_clr_i = 1'b0;
    dt_rise_i = 8'd0; dt_fall_i = 8'd0;
    @(negedge clk_i);
    cyc(E_OFF, "rst0");
    cyc(E_OFF, "rst1");

    // Enable from reset with pwm high: 4 dead cycles for dt_rise=3
    rst_ni = 1'b1; en_i = 1'b1; pwm_i = 1'b1; dt_rise_i = 8'd3; dt_fall_i = 8'd5;
    cyc(E_DT, "a_dt_entry");
    dt_rise_i = 8'd0;  // must be ignored mid dead time
    repeat (3) cyc(E_DT, "a_dt_hold");
    cyc(E_HI, "a_hi");
    cyc(E_HI, "a_hi_hold");

    // Falling edge with dt_fall=5: 6 dead cycles then ls
    pwm_i = 1'b0;
    cyc(E_DT, "b_fall_n");
    dt_fall_i = 8'd1;
    repeat (5) cyc(E_DT, "b_dtlo");
    cyc(E_LO, "b_lo_n6");
    cyc(E_LO, "b_lo_hold");
    pwm_i = 1'b1; dt_rise_i = 8'd0;
    cyc(E_DT, "b_dt0_rise");
    cyc(E_HI, "b_hi_dt0");
    pwm_i = 1'b0; dt_fall_i = 8'd0;
    cyc(E_DT, "b_dt0_fall");
    cyc(E_LO, "b_lo_dt0");

    // Pwm pulse shorter than dead time: no hs, abort into DT_LO
    pwm_i = 1'b1; dt_rise_i = 8'd10; dt_fall_i = 8'd2;
    repeat (4) cyc(E_DT, "c_short_hi");
    pwm_i = 1'b0;
    repeat (3) cyc(E_DT, "c_abort_lo");
    cyc(E_LO, "c_lo_back");

    // Enable drop and re-entry
    en_i = 1'b0;
    cyc(E_OFF, "d_disable");
    cyc(E_OFF, "d_disable_hold");
    en_i = 1'b1; dt_fall_i = 8'd1;
    repeat (2) cyc(E_DT, "d_reentry_dt");
    cyc(E_LO, "d_reentry_lo");

    // 3-cycle fault glitch is rejected
    fault_i = 1'b1;
    repeat (3) cyc(E_LO, "e_glitch");
    fault_i = 1'b0;
    repeat (4) cyc(E_LO, "e_glitch_reject");

    // Held fault: declared on the 7th edge, single irq pulse
    fault_i = 1'b1;
    repeat (6) cyc(E_LO, "e_filter");
    cyc(E_FIRQ, "e_fault_decl");
    cyc(E_FLT, "e_irq_once");

    // Clear while fault still present is ignored
    fault_clr_i = 1'b1;
    cyc(E_FLT, "f_clr_blocked");
    fault_clr_i = 1'b0;
    cyc(E_FLT, "f_hold");
    fault_i = 1'b0; pwm_i = 1'b1; dt_rise_i = 8'd2;
    repeat (3) cyc(E_FLT, "f_wait_sync");
    fault_clr_i = 1'b1;
    cyc(E_OFF, "f_clr_exit");
    fault_clr_i = 1'b0;
    repeat (3) cyc(E_DT, "f_dt_after_clr");
    cyc(E_HI, "f_hi");

    // Async reset while high side is on, then full dead time on release
    async_rst();
    cyc(E_OFF, "g_rst_hold");
    rst_ni = 1'b1;
    repeat (3) cyc(E_DT, "g_dt_after_rst");
    cyc(E_HI, "g_hi");
    en_i = 1'b0;
    cyc(E_OFF, "g_disable");

    repeat (2) @(negedge clk_i);
    n_chk++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
